pc_gen: RTL and testbench

//  Parametrised fetch-PC generator; next generation of the core's program counter. Drives pc_out to the IM.

---
 rtl/pc_gen.sv | 120 ++++++++++++
 tb/tb_pc_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator: sequential advance, branch redirect (buffered across stalls),
// soft reset, trap return and edge-detected interrupt entry with vectored targets.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     NUM_IRQ   = 4,
    parameter bit              VECTORED  = 1'b1,
    parameter int unsigned     INC       = 4,
    localparam int unsigned    CW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_reset,
    input  logic               im_stall,
    input  logic               dm_stall,
    input  logic               csr_stall,
    input  logic               branch_valid,
    input  logic [XLEN-1:0]    branch_target,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               irq_en,
    input  logic [XLEN-1:0]    tvec_base,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    output logic [XLEN-1:0]    pc_out,
    output logic               trap_taken,
    output logic [CW-1:0]      trap_cause,
    output logic [XLEN-1:0]    trap_epc,
    output logic               in_isr
);

    typedef enum logic {RUN, ISR} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_rise;
    logic               buf_valid;
    logic [XLEN-1:0]    buf_pc;
    logic               stall;
    logic               trap;
    logic [XLEN-1:0]    seq_next;
    logic [XLEN-1:0]    vec_base;
    logic [XLEN-1:0]    trap_target;
    logic [CW-1:0]      irq_cause;

    assign stall    = im_stall | dm_stall | csr_stall;
    assign irq_rise = irq_req & ~irq_q;
    assign vec_base = {tvec_base[XLEN-1:2], 2'b00};
    assign in_isr   = (state == ISR);
    assign trap     = (state == RUN) & irq_en & (|pending) & ~ret_valid & ~soft_reset;

    // A fresh redirect from EX is newer than one parked during a stall, so it wins.
    always_comb begin
        seq_next = pc_out + XLEN'(INC);
        if (stall)
            seq_next = pc_out;
        else if (branch_valid)
            seq_next = branch_target;
        else if (buf_valid)
            seq_next = buf_pc;
    end

    // Lowest-index pending line has highest priority.
    always_comb begin
        irq_cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i])
                irq_cause = CW'(i);
        end
    end

    assign trap_target = VECTORED ? (vec_base + (XLEN'(irq_cause) << 2)) : vec_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out     <= RESET_VEC;
            trap_taken <= 1'b0;
            trap_cause <= '0;
            trap_epc   <= '0;
            irq_q      <= '0;
            pending    <= '0;
            buf_valid  <= 1'b0;
            buf_pc     <= '0;
            state      <= RUN;
        end else begin
            irq_q      <= irq_req;
            trap_taken <= 1'b0;
            if (soft_reset) begin
                pc_out    <= RESET_VEC;
                pending   <= '0;
                buf_valid <= 1'b0;
                state     <= RUN;
            end else if (ret_valid) begin
                pc_out    <= ret_pc;
                pending   <= pending | irq_rise;
                buf_valid <= 1'b0;
                state     <= RUN;
            end else if (trap) begin
                // New edge on the serviced line re-arms it: set beats clear.
                pc_out     <= trap_target;
                trap_epc   <= seq_next;
                trap_cause <= irq_cause;
                trap_taken <= 1'b1;
                pending    <= (pending & ~(NUM_IRQ'(1) << irq_cause)) | irq_rise;
                buf_valid  <= 1'b0;
                state      <= ISR;
            end else begin
                pc_out  <= seq_next;
                pending <= pending | irq_rise;
                if (stall && branch_valid) begin
                    buf_valid <= 1'b1;
                    buf_pc    <= branch_target;
                end else if (!stall) begin
                    buf_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic against a
// cycle-level behavioural model of the fetch-PC rules.
module tb_pc_gen;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_IRQ = 4;
    localparam int unsigned CW      = 2;

    logic               clk;
    logic               reset, soft_reset, im_stall, dm_stall, csr_stall;
    logic               branch_valid, irq_en, ret_valid;
    logic [XLEN-1:0]    branch_target, tvec_base, ret_pc;
    logic [NUM_IRQ-1:0] irq_req;
    logic [XLEN-1:0]    pc_out, trap_epc;
    logic               trap_taken, in_isr;
    logic [CW-1:0]      trap_cause;

    pc_gen #(.XLEN(XLEN), .RESET_VEC(32'h0), .NUM_IRQ(NUM_IRQ), .VECTORED(1'b1), .INC(4)) dut (
        .clk(clk), .reset(reset), .soft_reset(soft_reset),
        .im_stall(im_stall), .dm_stall(dm_stall), .csr_stall(csr_stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .irq_req(irq_req), .irq_en(irq_en), .tvec_base(tvec_base),
        .ret_valid(ret_valid), .ret_pc(ret_pc),
        .pc_out(pc_out), .trap_taken(trap_taken), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .in_isr(in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        logic [31:0] pc;
        logic        tt;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic        isr;
    } exp_t;

    exp_t        sbq[$];
    int unsigned edge_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model state
    logic [31:0] m_pc = '0, m_bufpc = '0, m_epc = '0;
    bit          m_bufv = 0, m_isr = 0, m_tt = 0;
    logic [1:0]  m_cause = '0;
    bit          m_pend[NUM_IRQ];
    bit          m_prev[NUM_IRQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_pending();
        for (int i = 0; i < NUM_IRQ; i++)
            if (m_pend[i]) return i;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic commit();
        exp_t        x;
        bit          st;
        logic [31:0] sn;
        int          c;
        if (reset) begin
            m_pc = '0; m_tt = 0; m_cause = '0; m_epc = '0; m_isr = 0; m_bufv = 0;
            for (int i = 0; i < NUM_IRQ; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
        end else begin
            st = im_stall || dm_stall || csr_stall;
            if (st)                sn = m_pc;
            else if (branch_valid) sn = branch_target;
            else if (m_bufv)       sn = m_bufpc;
            else                   sn = m_pc + 32'd4;
            m_tt = 0;
            c = lowest_pending();
            if (soft_reset) begin
                m_pc = '0; m_bufv = 0; m_isr = 0;
                for (int i = 0; i < NUM_IRQ; i++) m_pend[i] = 0;
            end else begin
                if (ret_valid) begin
                    m_pc = ret_pc; m_bufv = 0; m_isr = 0;
                end else if (!m_isr && irq_en && c >= 0) begin
                    m_pc = {tvec_base[31:2], 2'b00} + 32'(c * 4);
                    m_epc = sn; m_cause = 2'(c); m_tt = 1; m_isr = 1; m_bufv = 0;
                    m_pend[c] = 0;
                end else begin
                    m_pc = sn;
                    if (st && branch_valid) begin m_bufv = 1; m_bufpc = branch_target; end
                    else if (!st) m_bufv = 0;
                end
                for (int i = 0; i < NUM_IRQ; i++)
                    if (irq_req[i] && !m_prev[i]) m_pend[i] = 1;
            end
            for (int i = 0; i < NUM_IRQ; i++) m_prev[i] = irq_req[i];
        end
        x.e = edge_cnt + 1; x.pc = m_pc; x.tt = m_tt; x.cause = m_cause; x.epc = m_epc; x.isr = m_isr;
        sbq.push_back(x);
    endtask

    // Monitor: compare DUT outputs at the falling edge after each modelled rising edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].e <= edge_cnt) begin
                x = sbq.pop_front();
                chk("pc_out", pc_out, x.pc);
                chk("trap_taken", 32'(trap_taken), 32'(x.tt));
                chk("trap_cause", 32'(trap_cause), 32'(x.cause));
                chk("trap_epc", trap_epc, x.epc);
                chk("in_isr", 32'(in_isr), 32'(x.isr));
            end
        end
    end

    task automatic idle();
        reset = 0; soft_reset = 0; im_stall = 0; dm_stall = 0; csr_stall = 0;
        branch_valid = 0; branch_target = '0; ret_valid = 0; ret_pc = '0;
    endtask

    task automatic cyc();
        commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          st;
        logic [3:0]  flip;
        idle(); irq_en = 0; tvec_base = '0; irq_req = '0;

        // Reset and free-running sequence
        reset = 1; cyc();
        chk("rst_pc", pc_out, 32'h0); chk("rst_isr", 32'(in_isr), 32'h0);
        chk("rst_tt", 32'(trap_taken), 32'h0); chk("rst_epc", trap_epc, 32'h0);
        cyc(); reset = 0;
        repeat (4) cyc();
        chk("seq_pc", pc_out, 32'h10);

        // Redirect during DM stall is held until the stall clears
        dm_stall = 1; branch_valid = 1; branch_target = 32'h100; cyc();
        chk("stall_hold", pc_out, 32'h10);
        branch_valid = 0; cyc(); cyc();
        chk("stall_hold2", pc_out, 32'h10);
        dm_stall = 0; cyc();
        chk("buf_redirect", pc_out, 32'h100);
        cyc();

        // Vectored trap entry on irq[2]
        branch_valid = 1; branch_target = 32'h3C; cyc(); branch_valid = 0;
        irq_en = 1; tvec_base = 32'h203; irq_req = 4'b0100; cyc();
        chk("pre_trap_pc", pc_out, 32'h40);
        cyc();
        chk("trap_pc", pc_out, 32'h208); chk("trap_epc", trap_epc, 32'h44);
        chk("trap_cause2", 32'(trap_cause), 32'd2); chk("trap_pulse", 32'(trap_taken), 32'd1);
        chk("isr_set", 32'(in_isr), 32'd1);
        cyc();
        chk("pulse_end", 32'(trap_taken), 32'd0);

        // No nesting; pending served in priority order after mret
        irq_req = 4'b1101; cyc(); cyc();
        chk("no_nest", pc_out, 32'h214);
        ret_valid = 1; ret_pc = 32'h44; cyc(); ret_valid = 0;
        chk("ret_pc", pc_out, 32'h44); chk("ret_isr", 32'(in_isr), 32'd0);
        cyc();
        chk("trap_c0_pc", pc_out, 32'h200); chk("trap_c0", 32'(trap_cause), 32'd0);
        ret_valid = 1; ret_pc = 32'h80; cyc(); ret_valid = 0;
        cyc();
        chk("trap_c3_pc", pc_out, 32'h20C); chk("trap_c3", 32'(trap_cause), 32'd3);
        chk("trap_c3_epc", trap_epc, 32'h84);

        // Soft reset beats return and drops pending requests
        irq_req = 4'b1111; cyc();
        soft_reset = 1; ret_valid = 1; ret_pc = 32'h500; cyc();
        soft_reset = 0; ret_valid = 0;
        chk("soft_pc", pc_out, 32'h0); chk("soft_isr", 32'(in_isr), 32'd0);
        cyc();
        chk("soft_nopend", pc_out, 32'h4); chk("cause_held", 32'(trap_cause), 32'd3);

        // Address wrap, then reset in the middle of an ISR
        branch_valid = 1; branch_target = 32'hFFFF_FFFC; cyc(); branch_valid = 0;
        cyc();
        chk("wrap", pc_out, 32'h0);
        irq_req = 4'b0000; cyc();
        irq_req = 4'b0001; cyc(); cyc();
        chk("isr_again", 32'(in_isr), 32'd1);
        reset = 1; cyc(); reset = 0;
        chk("midisr_rst_pc", pc_out, 32'h0); chk("midisr_rst_isr", 32'(in_isr), 32'd0);
        irq_req = '0;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset      = ($urandom_range(0, 299) == 0);
            soft_reset = ($urandom_range(0, 149) == 0);
            im_stall   = ($urandom_range(0, 5) == 0);
            dm_stall   = ($urandom_range(0, 7) == 0);
            csr_stall  = ($urandom_range(0, 9) == 0);
            st = im_stall || dm_stall || csr_stall;
            branch_valid  = ($urandom_range(0, 3) == 0) && !(m_bufv && !st);
            branch_target = {$urandom(), 2'b00} >> 2 << 2;
            ret_valid  = ($urandom_range(0, m_isr ? 8 : 40) == 0);
            ret_pc     = $urandom() & 32'hFFFF_FFFC;
            irq_en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) tvec_base = $urandom();
            flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            irq_req = irq_req ^ flip;
            cyc();
        end

        idle(); cyc();
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
